// File: rtl/sample_delay_line_pkg.sv
// rtl/sample_delay_line_pkg.sv - shared constants and FSM encoding for the sample delay line
// Contents: default address width, DAC mid-scale idle code, sequencer state type.
package sample_delay_line_pkg;

    localparam int         DEFAULT_ADDR_W     = 10;
    localparam logic [7:0] DEFAULT_IDLE_VALUE = 8'h80;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_ACCESS = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

endpackage

// File: rtl/sample_delay_line_ram.sv
// rtl/sample_delay_line_ram.sv - simple dual-port sample RAM, registered read, no reset
// Ports: clk; we/wr_addr/wr_data write port; re/rd_addr read port; rd_data registered
// read data, held between read enables.
module delay_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_delay_line.sv
// rtl/sample_delay_line.sv - circular-buffer delay stage between ADC capture and DAC latch
// Ports: qzt_clk system clock; reset async active-low; sample_clk divided sample clock
// (rising edge used); adc_data input sample; delay requested delay in samples; hold
// freezes capture/output; bypass routes current sample to output; dac_data delayed
// sample; dac_valid one-cycle update pulse; filled buffer holds at least delay samples.
module sample_delay_line
    import sample_delay_line_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = DEFAULT_ADDR_W,
    parameter logic [DATA_W-1:0] IDLE_VALUE = DATA_W'(DEFAULT_IDLE_VALUE)
) (
    input  logic              qzt_clk,
    input  logic              reset,
    input  logic              sample_clk,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [ADDR_W-1:0] delay,
    input  logic              hold,
    input  logic              bypass,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic              filled
);

    state_t            state, state_next;
    logic              s_meta, s_sync, s_old;
    logic              strobe;
    logic              accept;
    logic              update;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill_count;
    logic [ADDR_W-1:0] fill_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] d_q;
    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] upd_value;

    // sample_clk has arbitrary phase: two-flop synchroniser, then edge register
    always_ff @(posedge qzt_clk or negedge reset) begin
        if (!reset) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
            s_old  <= 1'b0;
        end else begin
            s_meta <= sample_clk;
            s_sync <= s_meta;
            s_old  <= s_sync;
        end
    end

    assign strobe = s_sync & ~s_old;

    // Unsigned ADDR_W-bit subtraction gives the circular wrap for free
    assign rd_addr = wr_ptr - delay;

    always_ff @(posedge qzt_clk or negedge reset) begin
        if (!reset) begin
            state <= S_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        update     = 1'b0;
        case (state)
            S_WAIT: begin
                if (strobe && !hold) begin
                    accept     = 1'b1;
                    state_next = S_ACCESS;
                end
            end
            S_ACCESS: state_next = S_UPDATE;
            S_UPDATE: begin
                update     = 1'b1;
                state_next = S_WAIT;
            end
            default:  state_next = S_WAIT;
        endcase
    end

    delay_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (qzt_clk),
        .we      (accept),
        .wr_addr (wr_ptr),
        .wr_data (adc_data),
        .re      (accept),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign fill_next = (&fill_count) ? fill_count : fill_count + ADDR_W'(1);

    // d=0 would read the slot being written, so the captured sample is forwarded instead
    always_comb begin
        upd_value = rd_data;
        if (bypass || (d_q == '0)) begin
            upd_value = x_q;
        end else if (fill_count < d_q) begin
            upd_value = IDLE_VALUE;
        end
    end

    always_ff @(posedge qzt_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            fill_count <= '0;
            d_q        <= '0;
            x_q        <= '0;
            dac_data   <= IDLE_VALUE;
            dac_valid  <= 1'b0;
            filled     <= 1'b0;
        end else begin
            dac_valid <= 1'b0;
            if (accept) begin
                d_q <= delay;
                x_q <= adc_data;
            end
            if (update) begin
                dac_data   <= upd_value;
                dac_valid  <= 1'b1;
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                fill_count <= fill_next;
                filled     <= (fill_next >= d_q);
            end
        end
    end

endmodule

// File: tb/tb_sample_delay_line.sv
// tb/tb_sample_delay_line.sv - self-checking bench for sample_delay_line
module tb_sample_delay_line;
    import sample_delay_line_pkg::*;

    localparam int         DEPTH = 1024;
    localparam logic [7:0] IDLE  = 8'h80;

    logic       qzt_clk = 1'b0;
    logic       reset;
    logic       sample_clk;
    logic [7:0] adc_data;
    logic [9:0] delay;
    logic       hold;
    logic       bypass;
    logic [7:0] dac_data;
    logic       dac_valid;
    logic       filled;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: every accepted sample since reset, in order
    logic [7:0] hist [$];
    logic [7:0] m_last;
    logic       m_filled;

    sample_delay_line dut (
        .qzt_clk    (qzt_clk),
        .reset      (reset),
        .sample_clk (sample_clk),
        .adc_data   (adc_data),
        .delay      (delay),
        .hold       (hold),
        .bypass     (bypass),
        .dac_data   (dac_data),
        .dac_valid  (dac_valid),
        .filled     (filled)
    );

    always #5 qzt_clk = ~qzt_clk;

    task automatic apply_reset();
        sample_clk = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge qzt_clk);
        #1 reset = 1'b1;
        hist.delete();
        m_last = IDLE;
        m_filled = 1'b0;
        repeat (3) @(posedge qzt_clk);
    endtask

    // One sample_clk period of 11 qzt cycles; reports the cycle (after the rising
    // sample_clk drive) of the dac_valid pulse, -1 if none, 99 if more than one cycle
    task automatic drive_sample(input logic [7:0] x, output int vcyc,
                                output logic [7:0] dd, output logic f);
        @(posedge qzt_clk);
        #1;
        adc_data = x;
        sample_clk = 1'b1;
        vcyc = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge qzt_clk);
            #1;
            if (dac_valid) vcyc = (vcyc == -1) ? c : 99;
            if (c == 5) sample_clk = 1'b0;
        end
        dd = dac_data;
        f = filled;
    endtask

    task automatic model_step(input logic [7:0] x, input int d, input logic byp,
                              output logic [7:0] exp_d, output logic exp_f);
        int n;
        int fill_old;
        n = hist.size();
        fill_old = (n < DEPTH - 1) ? n : DEPTH - 1;
        if (byp || d == 0)     exp_d = x;
        else if (fill_old < d) exp_d = IDLE;
        else                   exp_d = hist[n - d];
        hist.push_back(x);
        n = n + 1;
        exp_f = (((n < DEPTH - 1) ? n : DEPTH - 1) >= d);
        m_last = exp_d;
        m_filled = exp_f;
    endtask

    task automatic test_reset();
        hold = 1'b0; bypass = 1'b0; delay = '0; adc_data = '0;
        apply_reset();
        n_cmp++; if (dac_data !== IDLE) begin n_bad++; $display("FAIL reset_dac_data got %h want %h", dac_data, IDLE); end
        n_cmp++; if (dac_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dac_valid got %b want 0", dac_valid); end
        n_cmp++; if (filled !== 1'b0) begin n_bad++; $display("FAIL reset_filled got %b want 0", filled); end
        n_cmp++; if (dut.wr_ptr !== 10'd0) begin n_bad++; $display("FAIL reset_wr_ptr got %0d want 0", dut.wr_ptr); end
    endtask

    task automatic test_delay3();
        logic [7:0] exp_data [6] = '{8'h80, 8'h80, 8'h80, 8'h01, 8'h02, 8'h03};
        logic       exp_fill [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int vcyc; logic [7:0] dd; logic f; logic [7:0] md; logic mf;
        delay = 10'd3;
        for (int i = 0; i < 6; i++) begin
            drive_sample(8'(i + 1), vcyc, dd, f);
            model_step(8'(i + 1), 3, 1'b0, md, mf);
            n_cmp++; if (vcyc !== 5) begin n_bad++; $display("FAIL d3_latency[%0d] got %0d want 5", i, vcyc); end
            n_cmp++; if (dd !== exp_data[i]) begin n_bad++; $display("FAIL d3_data[%0d] got %h want %h", i, dd, exp_data[i]); end
            n_cmp++; if (f !== exp_fill[i]) begin n_bad++; $display("FAIL d3_filled[%0d] got %b want %b", i, f, exp_fill[i]); end
        end
    endtask

    task automatic test_delay_zero();
        int vcyc; logic [7:0] dd; logic f; logic [7:0] md; logic mf; logic [7:0] x;
        delay = 10'd0;
        drive_sample(8'h5A, vcyc, dd, f);
        model_step(8'h5A, 0, 1'b0, md, mf);
        n_cmp++; if (dd !== 8'h5A) begin n_bad++; $display("FAIL d0_first got %h want 5a", dd); end
        n_cmp++; if (f !== 1'b1) begin n_bad++; $display("FAIL d0_filled got %b want 1", f); end
        for (int i = 0; i < 5; i++) begin
            x = 8'($urandom);
            drive_sample(x, vcyc, dd, f);
            model_step(x, 0, 1'b0, md, mf);
            n_cmp++; if (dd !== md || vcyc !== 5) begin n_bad++; $display("FAIL d0_rand[%0d] got %h/%0d want %h/5", i, dd, vcyc, md); end
        end
    endtask

    task automatic test_hold();
        int vcyc; logic [7:0] dd; logic f; logic [7:0] md; logic mf;
        apply_reset();
        delay = 10'd4;
        for (int i = 0; i < 20; i++) begin
            hold = (i >= 8 && i <= 10);
            drive_sample(8'(i), vcyc, dd, f);
            if (hold) begin
                n_cmp++; if (vcyc !== -1) begin n_bad++; $display("FAIL hold_valid[%0d] got %0d want -1", i, vcyc); end
                n_cmp++; if (dd !== m_last) begin n_bad++; $display("FAIL hold_frozen[%0d] got %h want %h", i, dd, m_last); end
            end else begin
                model_step(8'(i), 4, 1'b0, md, mf);
                n_cmp++; if (vcyc !== 5) begin n_bad++; $display("FAIL hold_latency[%0d] got %0d want 5", i, vcyc); end
                n_cmp++; if (dd !== md) begin n_bad++; $display("FAIL hold_data[%0d] got %h want %h", i, dd, md); end
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_delay_change();
        int vcyc; logic [7:0] dd; logic f; logic [7:0] md; logic mf; logic [7:0] x;
        apply_reset();
        delay = 10'd2;
        for (int i = 0; i < 4; i++) begin
            x = 8'($urandom);
            drive_sample(x, vcyc, dd, f);
            model_step(x, 2, 1'b0, md, mf);
        end
        n_cmp++; if (f !== 1'b1) begin n_bad++; $display("FAIL dchg_filled_before got %b want 1", f); end
        delay = 10'd10;
        for (int i = 0; i < 12; i++) begin
            x = 8'($urandom);
            drive_sample(x, vcyc, dd, f);
            model_step(x, 10, 1'b0, md, mf);
            n_cmp++; if (dd !== md) begin n_bad++; $display("FAIL dchg_data[%0d] got %h want %h", i, dd, md); end
            n_cmp++; if (f !== mf) begin n_bad++; $display("FAIL dchg_filled[%0d] got %b want %b", i, f, mf); end
            if (i == 0) begin
                n_cmp++; if (dd !== IDLE) begin n_bad++; $display("FAIL dchg_first_idle got %h want 80", dd); end
            end
        end
        bypass = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = 8'($urandom);
            drive_sample(x, vcyc, dd, f);
            model_step(x, 10, 1'b1, md, mf);
            n_cmp++; if (dd !== x) begin n_bad++; $display("FAIL bypass[%0d] got %h want %h", i, dd, x); end
        end
        bypass = 1'b0;
    endtask

    task automatic test_long_wrap();
        int vcyc; logic [7:0] dd; logic f; logic [7:0] md; logic mf;
        int first_live;
        int errs;
        apply_reset();
        delay = 10'd1023;
        first_live = -1;
        errs = 0;
        for (int i = 0; i < 1100; i++) begin
            drive_sample(8'(i % 256), vcyc, dd, f);
            model_step(8'(i % 256), 1023, 1'b0, md, mf);
            if (first_live == -1 && dd !== IDLE) first_live = i;
            n_cmp++;
            if (dd !== md || f !== mf || vcyc !== 5) begin
                n_bad++;
                errs++;
                if (errs <= 5) $display("FAIL wrap_step[%0d] got %h/%b/%0d want %h/%b/5", i, dd, f, vcyc, md, mf);
            end
            if (i == 1023) begin
                n_cmp++; if (dd !== 8'h00) begin n_bad++; $display("FAIL wrap_1024th got %h want 00", dd); end
            end
        end
        n_cmp++; if (first_live !== 1023) begin n_bad++; $display("FAIL wrap_first_live got %0d want 1023", first_live); end
        n_cmp++; if (dd !== 8'd76) begin n_bad++; $display("FAIL wrap_last got %0d want 76", dd); end
        n_cmp++; if (dut.wr_ptr !== 10'd76) begin n_bad++; $display("FAIL wrap_ptr got %0d want 76", dut.wr_ptr); end
    endtask

    task automatic test_reset_mid();
        int vcyc; logic [7:0] dd; logic f; logic [7:0] md; logic mf;
        apply_reset();
        delay = 10'd1;
        drive_sample(8'h11, vcyc, dd, f);
        model_step(8'h11, 1, 1'b0, md, mf);
        drive_sample(8'h22, vcyc, dd, f);
        model_step(8'h22, 1, 1'b0, md, mf);
        n_cmp++; if (dd !== 8'h11) begin n_bad++; $display("FAIL rmid_pre got %h want 11", dd); end
        @(posedge qzt_clk);
        #1;
        adc_data = 8'h33;
        sample_clk = 1'b1;
        repeat (3) @(posedge qzt_clk);
        #1;
        n_cmp++; if (dut.state !== S_ACCESS) begin n_bad++; $display("FAIL rmid_state got %0d want %0d", dut.state, S_ACCESS); end
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (dac_data !== IDLE) begin n_bad++; $display("FAIL rmid_dac_data got %h want 80", dac_data); end
        n_cmp++; if (dac_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_dac_valid got %b want 0", dac_valid); end
        sample_clk = 1'b0;
        repeat (3) @(posedge qzt_clk);
        #1 reset = 1'b1;
        hist.delete();
        m_last = IDLE;
        m_filled = 1'b0;
        repeat (3) @(posedge qzt_clk);
        n_cmp++; if (dut.wr_ptr !== 10'd0) begin n_bad++; $display("FAIL rmid_ptr got %0d want 0", dut.wr_ptr); end
        drive_sample(8'h44, vcyc, dd, f);
        model_step(8'h44, 1, 1'b0, md, mf);
        n_cmp++; if (dd !== IDLE || vcyc !== 5) begin n_bad++; $display("FAIL rmid_next got %h/%0d want 80/5", dd, vcyc); end
        n_cmp++; if (dut.wr_ptr !== 10'd1) begin n_bad++; $display("FAIL rmid_ptr_next got %0d want 1", dut.wr_ptr); end
    endtask

    task automatic test_random();
        int vcyc; logic [7:0] dd; logic f; logic [7:0] md; logic mf; logic [7:0] x;
        int d;
        apply_reset();
        d = 0;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 20);
            delay = 10'(d);
            bypass = ($urandom_range(0, 7) == 0);
            hold = ($urandom_range(0, 7) == 0);
            x = 8'($urandom);
            drive_sample(x, vcyc, dd, f);
            if (hold) begin
                n_cmp++;
                if (vcyc !== -1 || dd !== m_last || f !== m_filled) begin
                    n_bad++;
                    $display("FAIL rand_hold[%0d] got %h/%b/%0d want %h/%b/-1", i, dd, f, vcyc, m_last, m_filled);
                end
            end else begin
                model_step(x, d, bypass, md, mf);
                n_cmp++;
                if (vcyc !== 5 || dd !== md || f !== mf) begin
                    n_bad++;
                    $display("FAIL rand_step[%0d] got %h/%b/%0d want %h/%b/5", i, dd, f, vcyc, md, mf);
                end
            end
        end
        hold = 1'b0;
        bypass = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        sample_clk = 1'b0;
        test_reset();
        test_delay3();
        test_delay_zero();
        test_hold();
        test_delay_change();
        test_reset_mid();
        test_random();
        test_long_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_delay_line.md
Name: sample_delay_line

Overview:
- Circular-buffer delay stage between the ADC sample path and the DAC output latch.
- On each rising edge of the divided sample clock (produced by the frequency divider), captures one 8-bit ADC sample into on-chip RAM.
- Presents the sample written `delay` sample-periods earlier to the DAC side.
- Owns write-pointer wrap, read-address arithmetic, fill tracking, and hold/bypass control.

Parameters:
- DATA_W, 8, sample width in bits.
- ADDR_W, 10, RAM address width; DEPTH = 2^ADDR_W = 1024 samples.
- IDLE_VALUE, 8'h80, DAC mid-scale code output while the buffer is not yet filled to the requested delay.

Ports:
- qzt_clk  in  1  system quartz clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample_clk  in  1  divided sample clock; arbitrary phase; only its rising edge is used.
- adc_data  in  DATA_W  ADC sample, stable around sample_clk rising edge.
- delay  in  ADDR_W  requested delay in samples, 0..DEPTH-1.
- hold  in  1  1 = freeze: ignore strobes, keep dac_data.
- bypass  in  1  1 = dac_data follows the current sample; RAM is still written.
- dac_data  out  DATA_W  delayed sample to the DAC latch.
- dac_valid  out  1  one-cycle pulse when dac_data updates.
- filled  out  1  1 once fill_count >= the latched delay.

Behaviour:
- Reset (reset=0, async): wr_ptr=0, fill_count=0, fsm=S_WAIT, dac_data=IDLE_VALUE, dac_valid=0, filled=0, sync flops=0. RAM contents are not cleared.
- Synchronisation: sample_clk passes through 2 flops, then an edge register. strobe = !s_old & s_sync, a 1-cycle pulse on qzt_clk.
- FSM states: S_WAIT, S_ACCESS, S_UPDATE.
- S_WAIT: on strobe with hold=0:
  - latch d = delay, x = adc_data;
  - write x to RAM[wr_ptr];
  - issue read at rd_addr = (wr_ptr - d) mod DEPTH, computed in ADDR_W-bit unsigned wrap arithmetic;
  - go to S_ACCESS.
- S_WAIT, other cases: strobe with hold=1 is dropped. No write, no pointer move, no dac_valid.
- S_ACCESS: RAM registered read data becomes available. Go to S_UPDATE.
- S_UPDATE: dac_data is set by the first matching rule:
  1. bypass=1 -> x
  2. d=0 -> x (forwarded; the RAM read-during-write value is never used)
  3. fill_count < d -> IDLE_VALUE
  4. otherwise -> RAM read data
- S_UPDATE, same cycle: dac_valid=1; wr_ptr += 1 (wraps 1023->0); fill_count saturates at DEPTH-1; filled = (fill_count_new >= d). Return to S_WAIT.
- Latency: dac_data/dac_valid change exactly 2 qzt_clk cycles after the strobe cycle, 5 cycles after sample_clk rises at the first sync flop.
- Strobe rule: a strobe arriving while not in S_WAIT is dropped. sample_clk period must be >= 8 qzt_clk cycles; shorter periods are outside spec.
- delay changes: take effect only at the next accepted strobe. Increasing delay beyond fill_count makes dac_data return IDLE_VALUE until fill catches up; filled drops accordingly.
- delay=DEPTH-1 reads the oldest surviving sample; the read address never equals the write address except when d=0, which is handled by rule 2.
- Reset mid-operation: immediate return to reset values; any in-flight write may or may not complete.
- hold asserted mid-access does not abort the current S_ACCESS/S_UPDATE sequence.

Decomposition:
- Shared package: IDLE_VALUE default; FSM state encoding (S_WAIT=2'd0, S_ACCESS=2'd1, S_UPDATE=2'd2); DEFAULT_ADDR_W=10.
- One sub-module, delay_ram: simple dual-port RAM with synchronous write and registered read (1-cycle read latency), DATA_W x DEPTH, no reset.
- Synchroniser and edge detector stay inline.

Test Plan:
- Reset, delay=3, feed 1,2,3,4,5,6 -> dac_data 80h,80h,80h,1,2,3; filled rises on the 3rd dac_valid; each dac_valid is 2 cycles after its strobe.
- delay=0, input 0x5A -> dac_data 0x5A on the same update, never a stale RAM value.
- delay=1023, feed 1100 ramp samples (value = index mod 256) -> first non-idle output is sample 0 on the 1024th update; wr_ptr wraps cleanly; sample 1099 outputs value of sample 76 (76).
- hold=1 for 3 strobes in the middle of a ramp -> no dac_valid, dac_data frozen; after release, sequence resumes with no gap in stored data.
- With delay=2 filled, switch delay to 10 -> IDLE_VALUE outputs until fill_count reaches 10, filled=0 in between; bypass=1 -> dac_data equals the current input immediately.
- Assert reset during S_ACCESS -> dac_data=80h and dac_valid=0 asynchronously; next strobe starts from wr_ptr=0.
